// File: rtl/idu2exu_hazard_if.sv
// idu2exu_hazard_if: IDU/EXU/WBU signals seen by the issue hazard unit; o_stall_cnt exists only with HAZARD_PERF_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
interface idu2exu_hazard_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = `DATA_WIDTH
);
  logic                      i_idu_valid;
  logic                      o_idu_ready;
  logic                      i_idu_rs1_en;
  logic                      i_idu_rs2_en;
  logic [REG_ADDR_WIDTH-1:0] i_idu_rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] i_idu_rs2_addr;
  logic [REG_ADDR_WIDTH-1:0] i_idu_rd_addr;
  logic                      i_idu_ctr_reg_wr_en;
  logic [DATA_WIDTH-1:0]     i_idu_rs1_data;
  logic [DATA_WIDTH-1:0]     i_idu_rs2_data;
  logic [DATA_WIDTH-1:0]     o_idu_rs1_data;
  logic [DATA_WIDTH-1:0]     o_idu_rs2_data;
  logic                      i_exu_valid;
  logic                      i_exu_reg_wr_en;
  logic [REG_ADDR_WIDTH-1:0] i_exu_rd_addr;
  logic                      i_exu_data_ok;
  logic [DATA_WIDTH-1:0]     i_exu_data;
  logic                      i_wbu_valid;
  logic                      i_wbu_reg_wr_en;
  logic [REG_ADDR_WIDTH-1:0] i_wbu_rd_addr;
  logic [DATA_WIDTH-1:0]     i_wbu_data;
  logic                      i_flush;
`ifdef HAZARD_PERF_EN
  logic [31:0]               o_stall_cnt;
`endif
  modport master (
    output i_idu_valid, i_idu_rs1_en, i_idu_rs2_en, i_idu_rs1_addr, i_idu_rs2_addr, i_idu_rd_addr,
           i_idu_ctr_reg_wr_en, i_idu_rs1_data, i_idu_rs2_data, i_exu_valid, i_exu_reg_wr_en,
           i_exu_rd_addr, i_exu_data_ok, i_exu_data, i_wbu_valid, i_wbu_reg_wr_en, i_wbu_rd_addr,
           i_wbu_data, i_flush,
`ifdef HAZARD_PERF_EN
    input  o_stall_cnt,
`endif
    input  o_idu_ready, o_idu_rs1_data, o_idu_rs2_data
  );
  modport slave (
    input  i_idu_valid, i_idu_rs1_en, i_idu_rs2_en, i_idu_rs1_addr, i_idu_rs2_addr, i_idu_rd_addr,
           i_idu_ctr_reg_wr_en, i_idu_rs1_data, i_idu_rs2_data, i_exu_valid, i_exu_reg_wr_en,
           i_exu_rd_addr, i_exu_data_ok, i_exu_data, i_wbu_valid, i_wbu_reg_wr_en, i_wbu_rd_addr,
           i_wbu_data, i_flush,
`ifdef HAZARD_PERF_EN
    output o_stall_cnt,
`endif
    output o_idu_ready, o_idu_rs1_data, o_idu_rs2_data
  );
endinterface

// File: rtl/idu2exu_hazard.sv
// idu2exu_hazard: pending-write scoreboard, EXU/WBU operand forwarding and issue ready for IDU->EXU.
// Optional HAZARD_PERF_EN adds a 32-bit stall cycle counter.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
module idu2exu_hazard #(
  parameter int REG_NUM        = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = `DATA_WIDTH,
  parameter int PEND_WIDTH     = 2
) (
  input logic              i_sys_clk,
  input logic              i_sys_rst_n,
  idu2exu_hazard_if.slave  bus
);
  logic [PEND_WIDTH-1:0]     pend [REG_NUM];
  logic [REG_ADDR_WIDTH-1:0] rs [2];
  logic                      en [2];
  logic [DATA_WIDTH-1:0]     rf [2];
  logic [DATA_WIDTH-1:0]     fwd [2];
  logic                      hz [2];
  logic                      exu_wr, retire, rd_live, full, ready, issue;
  assign rs[0] = bus.i_idu_rs1_addr;
  assign rs[1] = bus.i_idu_rs2_addr;
  assign en[0] = bus.i_idu_rs1_en;
  assign en[1] = bus.i_idu_rs2_en;
  assign rf[0] = bus.i_idu_rs1_data;
  assign rf[1] = bus.i_idu_rs2_data;
  assign exu_wr  = bus.i_exu_valid && bus.i_exu_reg_wr_en;
  assign retire  = bus.i_wbu_valid && bus.i_wbu_reg_wr_en && bus.i_wbu_rd_addr != '0;
  assign rd_live = bus.i_idu_ctr_reg_wr_en && bus.i_idu_rd_addr != '0;
  // A same-cycle retire of rd frees a slot, so the counter at max is not yet full.
  assign full  = rd_live && pend[bus.i_idu_rd_addr] == '1 && !(retire && bus.i_wbu_rd_addr == bus.i_idu_rd_addr);
  assign ready = i_sys_rst_n && !hz[0] && !hz[1] && !full && !bus.i_flush;
  assign issue = bus.i_idu_valid && ready && rd_live;
  for (genvar s = 0; s < 2; s++) begin : g_src
    logic                  live, em, wm;
    logic [PEND_WIDTH-1:0] p;
    assign p       = pend[rs[s]];
    assign live    = en[s] && rs[s] != '0;
    assign em      = exu_wr && bus.i_exu_rd_addr == rs[s];
    // WBU data is only the latest value when it is the sole write still in flight.
    assign wm      = retire && bus.i_wbu_rd_addr == rs[s] && p == PEND_WIDTH'(1);
    assign hz[s]   = live && (em ? !bus.i_exu_data_ok : !wm && p != '0);
    assign fwd[s]  = !live ? rf[s] : em ? bus.i_exu_data : wm ? bus.i_wbu_data : rf[s];
  end
  assign bus.o_idu_ready    = ready;
  assign bus.o_idu_rs1_data = fwd[0];
  assign bus.o_idu_rs2_data = fwd[1];
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n)
    if (!i_sys_rst_n) pend <= '{default: '0};
    else if (bus.i_flush) pend <= '{default: '0};
    else
      for (int r = 1; r < REG_NUM; r++) begin
        if (issue && bus.i_idu_rd_addr == REG_ADDR_WIDTH'(r) && !(retire && bus.i_wbu_rd_addr == REG_ADDR_WIDTH'(r)))
          pend[r] <= pend[r] + PEND_WIDTH'(1);
        else if (retire && bus.i_wbu_rd_addr == REG_ADDR_WIDTH'(r) && !(issue && bus.i_idu_rd_addr == REG_ADDR_WIDTH'(r)) && pend[r] != '0)
          pend[r] <= pend[r] - PEND_WIDTH'(1);
      end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n)
    if (!i_sys_rst_n) bus.o_stall_cnt <= '0;
    else if (bus.i_idu_valid && !ready && !bus.i_flush) bus.o_stall_cnt <= bus.o_stall_cnt + 32'd1;
`endif
endmodule

// File: tb/tb_idu2exu_hazard.sv
// tb_idu2exu_hazard: table-driven directed checks of the hazard unit plus reset/perf sequences.
module tb_idu2exu_hazard;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  idu2exu_hazard_if bus();
  idu2exu_hazard dut (.i_sys_clk(clk), .i_sys_rst_n(rst_n), .bus(bus));
  typedef struct {
    logic v, r1e; logic [4:0] r1; logic r2e; logic [4:0] r2; logic wr; logic [4:0] rd;
    logic ev, ew; logic [4:0] erd; logic eok; logic [31:0] ed;
    logic wv; logic [4:0] wrd; logic [31:0] wd; logic fl;
    logic rdy; logic [31:0] d1, d2;
  } vec_t;
  vec_t tbl[$];
  int tests = 0, fails = 0;
  int exp_stall = 0;
  function automatic logic [31:0] rf(input int a);
    return 32'hA000_0000 | 32'(a);
  endfunction
  task automatic add(input int v, r1e, r1, r2e, r2, wr, rd, ev, ew, erd, eok, ed, wv, wrd, wd, fl, rdy, d1, d2);
    tbl.push_back('{1'(v), 1'(r1e), 5'(r1), 1'(r2e), 5'(r2), 1'(wr), 5'(rd), 1'(ev), 1'(ew), 5'(erd), 1'(eok), 32'(ed),
                    1'(wv), 5'(wrd), 32'(wd), 1'(fl), 1'(rdy), 32'(d1), 32'(d2)});
  endtask
  task automatic apply(input vec_t t);
    bus.i_idu_valid = t.v; bus.i_idu_rs1_en = t.r1e; bus.i_idu_rs1_addr = t.r1;
    bus.i_idu_rs2_en = t.r2e; bus.i_idu_rs2_addr = t.r2; bus.i_idu_ctr_reg_wr_en = t.wr; bus.i_idu_rd_addr = t.rd;
    bus.i_idu_rs1_data = rf(int'(t.r1)); bus.i_idu_rs2_data = rf(int'(t.r2));
    bus.i_exu_valid = t.ev; bus.i_exu_reg_wr_en = t.ew; bus.i_exu_rd_addr = t.erd; bus.i_exu_data_ok = t.eok; bus.i_exu_data = t.ed;
    bus.i_wbu_valid = t.wv; bus.i_wbu_reg_wr_en = t.wv; bus.i_wbu_rd_addr = t.wrd; bus.i_wbu_data = t.wd;
    bus.i_flush = t.fl;
  endtask
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", n, act, exp);
    end
  endtask
  vec_t idle;
  initial begin
    idle = '{default: '0};
    apply(idle);
    #2 check("reset_ready", 32'(bus.o_idu_ready), 0);
`ifdef HAZARD_PERF_EN
    check("reset_stall_cnt", bus.o_stall_cnt, 0);
`endif
    @(negedge clk); @(negedge clk); rst_n = 1;
    add(0,0,0,0,0,0,0, 0,0,0,0,0,          0,0,0,          0, 1,rf(0),rf(0));
    add(1,1,1,0,0,1,3, 0,0,0,0,0,          0,0,0,          0, 1,rf(1),rf(0));
    add(1,1,3,0,0,0,0, 1,1,3,1,32'h1234,   0,0,0,          0, 1,32'h1234,rf(0));
    add(0,1,3,0,0,0,0, 0,0,0,0,0,          1,3,32'h5555,   0, 1,32'h5555,rf(0));
    add(1,1,3,0,0,0,0, 0,0,0,0,0,          0,0,0,          0, 1,rf(3),rf(0));
    add(1,0,0,0,0,1,7, 0,0,0,0,0,          0,0,0,          0, 1,rf(0),rf(0));
    add(1,0,0,1,7,0,0, 1,1,7,0,32'hDEAD,   0,0,0,          0, 0,rf(0),32'hDEAD);
    add(1,0,0,1,7,0,0, 0,0,0,0,0,          1,7,32'hCAFE,   0, 1,rf(0),32'hCAFE);
    add(1,0,0,0,0,1,8, 0,0,0,0,0,          0,0,0,          0, 1,rf(0),rf(0));
    add(1,1,8,0,0,0,0, 0,0,0,0,0,          0,0,0,          0, 0,rf(8),rf(0));
    add(1,0,8,0,0,0,0, 0,0,0,0,0,          0,0,0,          0, 1,rf(8),rf(0));
    add(1,0,0,0,0,1,9, 0,0,0,0,0,          0,0,0,          0, 1,rf(0),rf(0));
    add(1,0,0,0,0,1,9, 0,0,0,0,0,          1,9,32'h9999,   0, 1,rf(0),rf(0));
    add(1,1,9,0,0,0,0, 0,0,0,0,0,          0,0,0,          0, 0,rf(9),rf(0));
    add(0,1,9,0,0,0,0, 0,0,0,0,0,          1,9,32'h9A9A,   0, 1,32'h9A9A,rf(0));
    add(1,1,9,0,0,0,0, 0,0,0,0,0,          0,0,0,          0, 1,rf(9),rf(0));
    add(1,1,0,1,0,1,0, 1,1,0,0,32'hBAD,    0,0,0,          0, 1,rf(0),rf(0));
    add(1,1,0,1,0,0,0, 0,0,0,0,0,          0,0,0,          0, 1,rf(0),rf(0));
    add(1,0,0,0,0,1,4, 0,0,0,0,0,          0,0,0,          0, 1,rf(0),rf(0));
    add(1,0,0,0,0,1,4, 0,0,0,0,0,          0,0,0,          0, 1,rf(0),rf(0));
    add(1,0,0,0,0,1,4, 0,0,0,0,0,          0,0,0,          0, 1,rf(0),rf(0));
    add(1,0,0,0,0,1,4, 0,0,0,0,0,          0,0,0,          0, 0,rf(0),rf(0));
    add(1,0,0,0,0,1,4, 0,0,0,0,0,          1,4,32'h4444,   0, 1,rf(0),rf(0));
    add(1,0,0,0,0,1,4, 0,0,0,0,0,          0,0,0,          0, 0,rf(0),rf(0));
    add(0,0,0,0,0,0,0, 0,0,0,0,0,          1,4,32'h4444,   0, 1,rf(0),rf(0));
    add(1,0,0,0,0,1,4, 0,0,0,0,0,          0,0,0,          0, 1,rf(0),rf(0));
    add(1,0,0,0,0,1,2, 0,0,0,0,0,          0,0,0,          0, 1,rf(0),rf(0));
    add(1,0,0,0,0,1,5, 0,0,0,0,0,          1,2,32'h2222,   1, 0,rf(0),rf(0));
    add(1,1,2,1,4,1,4, 0,0,0,0,0,          0,0,0,          0, 1,rf(2),rf(4));
    add(0,0,0,0,0,0,0, 0,0,0,0,0,          1,4,32'h4444,   0, 1,rf(0),rf(0));
    add(0,1,2,0,0,0,0, 0,0,0,0,0,          1,2,32'h2222,   0, 1,rf(2),rf(0));
    add(0,1,2,0,0,0,0, 0,0,0,0,0,          0,0,0,          0, 1,rf(2),rf(0));
    foreach (tbl[i]) begin
      @(negedge clk);
      apply(tbl[i]);
      #1;
      check($sformatf("v%0d_ready", i), 32'(bus.o_idu_ready), 32'(tbl[i].rdy));
      check($sformatf("v%0d_rs1", i), bus.o_idu_rs1_data, tbl[i].d1);
      check($sformatf("v%0d_rs2", i), bus.o_idu_rs2_data, tbl[i].d2);
`ifdef HAZARD_PERF_EN
      check($sformatf("v%0d_stall_cnt", i), bus.o_stall_cnt, 32'(exp_stall));
`endif
      if (tbl[i].v && !tbl[i].rdy && !tbl[i].fl) exp_stall++;
    end
    // Reset mid-traffic: two writes to x5 in flight, then async reset.
    @(negedge clk);
    apply(idle); bus.i_idu_valid = 1; bus.i_idu_ctr_reg_wr_en = 1; bus.i_idu_rd_addr = 5;
    #1 check("rst_seq_issue1", 32'(bus.o_idu_ready), 1);
    @(negedge clk);
    #1 check("rst_seq_issue2", 32'(bus.o_idu_ready), 1);
    @(negedge clk);
    apply(idle); bus.i_idu_valid = 1; bus.i_idu_rs1_en = 1; bus.i_idu_rs1_addr = 5; bus.i_idu_rs1_data = rf(5);
    #1 check("rst_seq_hazard", 32'(bus.o_idu_ready), 0);
    rst_n = 0;
    #1 check("rst_seq_in_reset", 32'(bus.o_idu_ready), 0);
`ifdef HAZARD_PERF_EN
    check("rst_seq_stall_cnt", bus.o_stall_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1;
    #1 check("rst_seq_ready", 32'(bus.o_idu_ready), 1);
    check("rst_seq_rs1", bus.o_idu_rs1_data, rf(5));
    @(negedge clk);
    #1 check("rst_seq_ready_after_edge", 32'(bus.o_idu_ready), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
